// File: rtl/reg_bank.sv
// NUM_CH-channel register bank with hold/load/increment/shift commands, sticky overflow flags and a registered read port.
// Commands land one edge after sampling and outa trails rd_sel by one edge; every command is accepted every cycle.
module reg_bank #(
    parameter int WIDTH    = 8,
    parameter int NUM_CH   = 4,
    parameter int SATURATE = 0,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [WIDTH-1:0]  data,
    input  logic [CH_W-1:0]   rd_sel,
    output logic [WIDTH-1:0]  outa,
    output logic [NUM_CH-1:0] ovf,
    input  logic [NUM_CH-1:0] clr_ovf
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_INC   = 2'b10;
    localparam logic [1:0] MODE_SHIFT = 2'b11;

    logic [WIDTH-1:0]  r_regs [NUM_CH];
    logic [WIDTH-1:0]  r_outa;
    logic [NUM_CH-1:0] r_ovf;

    logic [WIDTH-1:0]  w_nxt [NUM_CH];
    logic [NUM_CH-1:0] w_set;
    logic [WIDTH-1:0]  w_rd;

    // An out-of-range ch_sel matches no channel, so the command is dropped.
    always_comb begin : p_next
        logic [WIDTH:0]   v_inc;
        logic [WIDTH-1:0] v_shl;
        v_inc = '0;
        v_shl = '0;
        w_set = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_nxt[i] = r_regs[i];
            v_inc    = {1'b0, r_regs[i]} + {{WIDTH{1'b0}}, 1'b1};
            v_shl    = r_regs[i] << 1;
            v_shl[0] = data[0];
            if (enable && (32'(ch_sel) == 32'(i))) begin
                case (mode)
                    MODE_HOLD: w_nxt[i] = r_regs[i];
                    MODE_LOAD: w_nxt[i] = data;
                    MODE_INC: begin
                        if (v_inc[WIDTH]) begin
                            w_nxt[i] = (SATURATE != 0) ? {WIDTH{1'b1}} : '0;
                            w_set[i] = 1'b1;
                        end else begin
                            w_nxt[i] = v_inc[WIDTH-1:0];
                        end
                    end
                    MODE_SHIFT: begin
                        w_nxt[i] = v_shl;
                        w_set[i] = r_regs[i][WIDTH-1];
                    end
                    default: w_nxt[i] = r_regs[i];
                endcase
            end
        end
    end

    always_comb begin : p_rd_mux
        w_rd = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (32'(rd_sel) == 32'(i)) begin
                w_rd = r_regs[i];
            end
        end
    end

    // Set events are OR'd in after the clear, so a set wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_regs[i] <= '0;
            end
            r_outa <= '0;
            r_ovf  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_regs[i] <= w_nxt[i];
            end
            r_outa <= w_rd;
            r_ovf  <= (r_ovf & ~clr_ovf) | w_set;
        end
    end

    assign outa = r_outa;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: three instances (wrap/4ch, saturate/4ch, wrap/3ch) share one stimulus stream.
module tb_reg_bank;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [1:0] mode;
    logic [1:0] ch_sel;
    logic [7:0] data;
    logic [1:0] rd_sel;
    logic [3:0] clr_ovf;

    logic [7:0] outa_w, outa_s, outa_n3;
    logic [3:0] ovf_w, ovf_s;
    logic [2:0] ovf_n3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_bank #(.WIDTH(8), .NUM_CH(4), .SATURATE(0)) u_w (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .ch_sel(ch_sel),
        .data(data), .rd_sel(rd_sel), .outa(outa_w), .ovf(ovf_w), .clr_ovf(clr_ovf)
    );

    reg_bank #(.WIDTH(8), .NUM_CH(4), .SATURATE(1)) u_s (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .ch_sel(ch_sel),
        .data(data), .rd_sel(rd_sel), .outa(outa_s), .ovf(ovf_s), .clr_ovf(clr_ovf)
    );

    reg_bank #(.WIDTH(8), .NUM_CH(3), .SATURATE(0)) u_n3 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .ch_sel(ch_sel),
        .data(data), .rd_sel(rd_sel), .outa(outa_n3), .ovf(ovf_n3), .clr_ovf(clr_ovf[2:0])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, take the edge, return 1ns after it.
    task automatic do_cmd(input logic e, input logic [1:0] m, input logic [1:0] c,
                          input logic [7:0] d, input logic [1:0] r, input logic [3:0] cl);
        enable  = e;
        mode    = m;
        ch_sel  = c;
        data    = d;
        rd_sel  = r;
        clr_ovf = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [1:0] r);
        do_cmd(1'b0, 2'b00, 2'd0, 8'h00, r, 4'b0000);
    endtask

    initial begin
        enable  = 1'b0;
        mode    = 2'b00;
        ch_sel  = 2'd0;
        data    = 8'h00;
        rd_sel  = 2'd0;
        clr_ovf = 4'b0000;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check("rst_async_outa", 32'(outa_w), 32'h00);
        check("rst_async_ovf", 32'(ovf_w), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_outa", 32'(outa_w), 32'h00);
        reset_n = 1'b1;

        // Load and read back
        do_cmd(1'b1, 2'b01, 2'd2, 8'hA5, 2'd2, 4'b0000);
        check("ld_same_edge", 32'(outa_w), 32'h00);
        idle(2'd2);
        check("ld_read", 32'(outa_w), 32'hA5);
        idle(2'd0);
        check("rd_ch0", 32'(outa_w), 32'h00);
        idle(2'd3);
        check("rd_ch3", 32'(outa_w), 32'h00);

        // Wrap versus saturate on ch1
        do_cmd(1'b1, 2'b01, 2'd1, 8'hFE, 2'd1, 4'b0000);
        do_cmd(1'b1, 2'b10, 2'd1, 8'h00, 2'd1, 4'b0000);
        check("inc1_outa", 32'(outa_w), 32'hFE);
        do_cmd(1'b1, 2'b10, 2'd1, 8'h00, 2'd1, 4'b0000);
        check("inc2_outa", 32'(outa_w), 32'hFF);
        check("wrap_ovf", 32'(ovf_w), 32'h2);
        check("sat_ovf1", 32'(ovf_s), 32'h2);
        idle(2'd1);
        check("wrap_val", 32'(outa_w), 32'h00);
        check("sat_val1", 32'(outa_s), 32'hFF);
        check("ovf_sticky", 32'(ovf_w), 32'h2);
        do_cmd(1'b0, 2'b00, 2'd0, 8'h00, 2'd1, 4'b0010);
        check("ovf_clr", 32'(ovf_w), 32'h0);

        // Saturation on ch0 and set-beats-clear
        do_cmd(1'b1, 2'b01, 2'd0, 8'hFF, 2'd0, 4'b0000);
        do_cmd(1'b1, 2'b10, 2'd0, 8'h00, 2'd0, 4'b0000);
        check("sat_ovf0", 32'(ovf_s), 32'h1);
        do_cmd(1'b1, 2'b10, 2'd0, 8'h00, 2'd0, 4'b0001);
        check("set_wins", 32'(ovf_s), 32'h1);
        check("clr_no_set", 32'(ovf_w), 32'h0);
        idle(2'd0);
        check("sat_hold", 32'(outa_s), 32'hFF);
        check("wrap_then_inc", 32'(outa_w), 32'h01);

        // Shift and ignored command on ch3
        do_cmd(1'b1, 2'b01, 2'd3, 8'h81, 2'd3, 4'b0000);
        do_cmd(1'b1, 2'b11, 2'd3, 8'h01, 2'd3, 4'b0000);
        check("shift_ovf", 32'(ovf_w), 32'h8);
        do_cmd(1'b0, 2'b01, 2'd3, 8'hFF, 2'd3, 4'b0000);
        check("shift_val", 32'(outa_w), 32'h03);
        idle(2'd3);
        check("en0_hold", 32'(outa_w), 32'h03);

        // Out-of-range command and read on the 3-channel instance
        do_cmd(1'b1, 2'b01, 2'd3, 8'hFF, 2'd0, 4'b0000);
        idle(2'd0);
        check("n3_ch0", 32'(outa_n3), 32'h01);
        idle(2'd1);
        check("n3_ch1", 32'(outa_n3), 32'h00);
        idle(2'd2);
        check("n3_ch2", 32'(outa_n3), 32'hA5);
        idle(2'd3);
        check("n3_rd_oor", 32'(outa_n3), 32'h00);
        check("n3_ovf", 32'(ovf_n3), 32'h0);

        // Read/write collision on ch2
        do_cmd(1'b1, 2'b01, 2'd2, 8'h10, 2'd2, 4'b0000);
        do_cmd(1'b1, 2'b10, 2'd2, 8'h00, 2'd2, 4'b0000);
        check("coll_old", 32'(outa_w), 32'h10);
        idle(2'd2);
        check("coll_new", 32'(outa_w), 32'h11);

        // Async reset mid-operation
        do_cmd(1'b1, 2'b01, 2'd0, 8'h11, 2'd3, 4'b0000);
        do_cmd(1'b1, 2'b01, 2'd1, 8'h22, 2'd3, 4'b0000);
        do_cmd(1'b1, 2'b01, 2'd2, 8'h33, 2'd3, 4'b0000);
        do_cmd(1'b1, 2'b01, 2'd3, 8'h44, 2'd3, 4'b0000);
        idle(2'd3);
        check("pre_rst_outa", 32'(outa_w), 32'h44);
        check("pre_rst_ovf", 32'(ovf_w), 32'h8);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_outa", 32'(outa_w), 32'h00);
        check("mid_rst_ovf", 32'(ovf_w), 32'h0);
        check("mid_rst_outa_s", 32'(outa_s), 32'h00);
        @(posedge clk);
        #1 reset_n = 1'b1;
        do_cmd(1'b1, 2'b10, 2'd0, 8'h00, 2'd0, 4'b0000);
        check("post_rst_old", 32'(outa_w), 32'h00);
        idle(2'd0);
        check("post_rst_inc", 32'(outa_w), 32'h01);
        idle(2'd3);
        check("post_rst_ch3", 32'(outa_w), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
